// File: rtl/axil_cmd_master.sv
// AXI4-Lite master that turns write/read/poll commands into single bus transactions
// and returns one response per command. Only one command is in flight at a time.
module axil_cmd_master #(
    parameter int AXIL_ADDR_BITS = 64,
    parameter int AXIL_DATA_BITS = 64,
    parameter int MAX_POLL       = 256,
    parameter int POLL_GAP       = 16,
    localparam int STRB_BITS     = AXIL_DATA_BITS / 8,
    localparam int PW            = $clog2(MAX_POLL + 1)
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [AXIL_ADDR_BITS-1:0] cmd_addr,
    input  logic [AXIL_DATA_BITS-1:0] cmd_data,
    input  logic [STRB_BITS-1:0]      cmd_strb,
    input  logic [AXIL_DATA_BITS-1:0] cmd_mask,
    output logic                      m_axil_awvalid,
    input  logic                      m_axil_awready,
    output logic [AXIL_ADDR_BITS-1:0] m_axil_awaddr,
    output logic                      m_axil_wvalid,
    input  logic                      m_axil_wready,
    output logic [AXIL_DATA_BITS-1:0] m_axil_wdata,
    output logic [STRB_BITS-1:0]      m_axil_wstrb,
    input  logic                      m_axil_bvalid,
    output logic                      m_axil_bready,
    input  logic [1:0]                m_axil_bresp,
    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,
    output logic [AXIL_ADDR_BITS-1:0] m_axil_araddr,
    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready,
    input  logic [AXIL_DATA_BITS-1:0] m_axil_rdata,
    input  logic [1:0]                m_axil_rresp,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [AXIL_DATA_BITS-1:0] rsp_data,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic [PW-1:0]             rsp_polls
);

    localparam int GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, GAP, RSP} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                op_q, op_d;
    logic [AXIL_ADDR_BITS-1:0] addr_q, addr_d;
    logic [AXIL_DATA_BITS-1:0] data_q, data_d;
    logic [STRB_BITS-1:0]      strb_q, strb_d;
    logic [AXIL_DATA_BITS-1:0] mask_q, mask_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic [PW-1:0]             poll_cnt_q, poll_cnt_d;
    logic [GW-1:0]             gap_cnt_q, gap_cnt_d;
    logic [AXIL_DATA_BITS-1:0] rdata_q, rdata_d;
    logic [1:0]                resp_q, resp_d;
    logic                      timeout_q, timeout_d;
    logic                      match;

    assign match = ((m_axil_rdata ^ data_q) & mask_q) == '0;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        strb_d     = strb_q;
        mask_d     = mask_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        timeout_d  = timeout_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    addr_d     = cmd_addr;
                    data_d     = cmd_data;
                    strb_d     = cmd_strb;
                    mask_d     = cmd_mask;
                    poll_cnt_d = '0;
                    rdata_d    = '0;
                    resp_d     = 2'b00;
                    timeout_d  = 1'b0;
                    if (cmd_op == OP_WR) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else if (cmd_op == OP_RSV) begin
                        resp_d  = 2'b10;
                        state_d = RSP;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            WR: begin
                if (m_axil_awready) awvalid_d = 1'b0;
                if (m_axil_wready)  wvalid_d  = 1'b0;
                // Each channel is retired on its own; move on once neither is outstanding.
                if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready))
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                if (m_axil_bvalid) begin
                    resp_d  = m_axil_bresp;
                    state_d = RSP;
                end
            end
            RD_ADDR: begin
                if (m_axil_arready) begin
                    poll_cnt_d = poll_cnt_q + PW'(1);
                    state_d    = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axil_rvalid) begin
                    rdata_d = m_axil_rdata;
                    resp_d  = m_axil_rresp;
                    if (op_q == OP_RD || match || m_axil_rresp != 2'b00) begin
                        state_d = RSP;
                    end else if (poll_cnt_q == PW'(MAX_POLL)) begin
                        timeout_d = 1'b1;
                        state_d   = RSP;
                    end else if (POLL_GAP == 0) begin
                        state_d = RD_ADDR;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(GAP_LAST)) state_d = RD_ADDR;
                else                            gap_cnt_d = gap_cnt_q + GW'(1);
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            mask_q     <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            rdata_q    <= '0;
            resp_q     <= 2'b00;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            mask_q     <= mask_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            timeout_q  <= timeout_d;
        end
    end

    // All handshake outputs decode registered state only, never a ready input.
    assign cmd_ready      = (state_q == IDLE) && !areset;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_wdata   = data_q;
    assign m_axil_wstrb   = strb_q;
    assign m_axil_bready  = (state_q == WR_RESP);
    assign m_axil_arvalid = (state_q == RD_ADDR);
    assign m_axil_araddr  = addr_q;
    assign m_axil_rready  = (state_q == RD_DATA);
    assign rsp_valid      = (state_q == RSP);
    assign rsp_data       = rdata_q;
    assign rsp_resp       = resp_q;
    assign rsp_timeout    = timeout_q;
    assign rsp_polls      = poll_cnt_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: behavioural AXI-Lite slave with programmable
// latencies, scoreboard of expected responses, and handshake/gap monitors.
module tb_axil_cmd_master;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int PWB = $clog2(4 + 1);

    logic          aclk, areset;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data, cmd_mask;
    logic [SW-1:0] cmd_strb;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;
    logic          rsp_valid, rsp_ready, rsp_timeout;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic [PWB-1:0] rsp_polls;

    axil_cmd_master #(.AXIL_ADDR_BITS(AW), .AXIL_DATA_BITS(DW), .MAX_POLL(4), .POLL_GAP(2)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_mask(cmd_mask),
        .m_axil_awvalid(awvalid), .m_axil_awready(awready), .m_axil_awaddr(awaddr),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_bresp(bresp),
        .m_axil_arvalid(arvalid), .m_axil_arready(arready), .m_axil_araddr(araddr),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout), .rsp_polls(rsp_polls)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- slave model ----------------
    int          aw_lat, w_lat, r_lat;
    logic [1:0]  rd_resp;
    logic [DW-1:0] rtab [64];
    int          aw_wait, w_wait, r_cnt;
    logic        aw_done, w_done, r_pend;
    logic [5:0]  r_idx;
    logic        aw_hs, w_hs, ar_hs, r_hs;

    assign awready = awvalid && (aw_wait >= aw_lat);
    assign wready  = wvalid && (w_wait >= w_lat);
    assign arready = arvalid;
    assign bresp   = 2'b00;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_wait <= 0; w_wait <= 0; aw_done <= 1'b0; w_done <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
            r_pend <= 1'b0; r_cnt <= 0; r_idx <= '0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            if (bvalid && bready) bvalid <= 1'b0;
            if ((aw_hs || w_hs) && (aw_hs || aw_done) && (w_hs || w_done)) begin
                bvalid <= 1'b1; aw_done <= 1'b0; w_done <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (r_hs) begin rvalid <= 1'b0; r_idx <= r_idx + 6'd1; end
            if (ar_hs) begin
                if (r_lat == 0) begin rvalid <= 1'b1; rdata <= rtab[r_idx]; rresp <= rd_resp; end
                else begin r_pend <= 1'b1; r_cnt <= r_lat - 1; end
            end else if (r_pend) begin
                if (r_cnt == 0) begin
                    rvalid <= 1'b1; rdata <= rtab[r_idx]; rresp <= rd_resp; r_pend <= 1'b0;
                end else r_cnt <= r_cnt - 1;
            end
        end
    end

    // ---------------- monitors ----------------
    int cyc = 0, aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, aw_hi_n = 0, w_hi_n = 0;
    int last_r_cyc = 0, gap_n = 0, gap_sum = 0, last_gap = 0;
    logic arv_prev = 1'b0, r_seen = 1'b0;
    logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
    logic [DW-1:0] last_wdata = '0;
    logic [SW-1:0] last_wstrb = '0;

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (awvalid) aw_hi_n <= aw_hi_n + 1;
        if (wvalid)  w_hi_n  <= w_hi_n + 1;
        if (aw_hs) begin aw_hs_n <= aw_hs_n + 1; last_awaddr <= awaddr; end
        if (w_hs)  begin w_hs_n <= w_hs_n + 1; last_wdata <= wdata; last_wstrb <= wstrb; end
        if (ar_hs) begin ar_hs_n <= ar_hs_n + 1; last_araddr <= araddr; end
        if (r_hs)  begin last_r_cyc <= cyc; r_seen <= 1'b1; end
        if (rsp_valid && rsp_ready) r_seen <= 1'b0;
        if (arvalid && !arv_prev && r_seen) begin
            gap_n    <= gap_n + 1;
            gap_sum  <= gap_sum + (cyc - last_r_cyc - 1);
            last_gap <= cyc - last_r_cyc - 1;
        end
        arv_prev <= arvalid;
    end

    // ---------------- checking ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          tmo;
        int            polls;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic [1:0] r, input logic t, input int p);
        exp_t e;
        e.data = d; e.resp = r; e.tmo = t; e.polls = p;
        exp_q.push_back(e);
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL %s_sb observed=unexpected_response expected=none", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, rsp_data, e.data);
            chk({tag, "_resp"}, 64'(rsp_resp), 64'(e.resp));
            chk({tag, "_tmo"}, 64'(rsp_timeout), 64'(e.tmo));
            chk({tag, "_polls"}, 64'(rsp_polls), 64'(e.polls));
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic [DW-1:0] m);
        int n;
        @(negedge aclk);
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_mask = m; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge aclk); n++; end
        if (!cmd_ready) chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int lat);
        lat = 0;
        do begin @(negedge aclk); lat++; end while (!rsp_valid && lat < 300);
        chk({tag, "_rsp_seen"}, 64'(rsp_valid), 64'd1);
        if (rsp_valid) check_rsp(tag);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, b_aw, b_w, b_ar, b_awhi, b_whi, b_gn, b_gs;
        logic [DW-1:0] s_data;
        logic [1:0] s_resp;
        logic s_tmo, stable;
        logic [PWB-1:0] s_polls;

        areset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
        cmd_strb = '0; cmd_mask = '0; rsp_ready = 1'b1;
        aw_lat = 0; w_lat = 0; r_lat = 0; rd_resp = 2'b00;
        for (int i = 0; i < 64; i++) rtab[i] = '0;

        // reset state
        #13;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        @(negedge aclk); @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // write with slow AW
        aw_lat = 3; w_lat = 0;
        b_aw = aw_hs_n; b_w = w_hs_n; b_awhi = aw_hi_n; b_whi = w_hi_n;
        push_exp(64'd0, 2'b00, 1'b0, 0);
        send_cmd(2'b00, 64'h18, 64'h1, 8'hFF, 64'h0);
        wait_rsp("wr_slow", lat);
        chk("wr_slow_aw_hs", 64'(aw_hs_n - b_aw), 64'd1);
        chk("wr_slow_w_hs", 64'(w_hs_n - b_w), 64'd1);
        chk("wr_slow_aw_hi", 64'(aw_hi_n - b_awhi), 64'd4);
        chk("wr_slow_w_hi", 64'(w_hi_n - b_whi), 64'd1);
        chk("wr_slow_awaddr", last_awaddr, 64'h18);
        chk("wr_slow_wdata", last_wdata, 64'h1);
        chk("wr_slow_wstrb", 64'(last_wstrb), 64'hFF);

        // zero-wait write latency
        aw_lat = 0;
        push_exp(64'd0, 2'b00, 1'b0, 0);
        send_cmd(2'b00, 64'h20, 64'hDEAD, 8'h0F, 64'h0);
        wait_rsp("wr_fast", lat);
        chk("wr_fast_latency", 64'(lat), 64'd3);
        chk("wr_fast_wstrb", 64'(last_wstrb), 64'h0F);

        // zero-wait read latency
        rtab[r_idx] = 64'h5;
        push_exp(64'h5, 2'b00, 1'b0, 1);
        send_cmd(2'b01, 64'h08, 64'h0, 8'h0, 64'h0);
        wait_rsp("rd_fast", lat);
        chk("rd_fast_latency", 64'(lat), 64'd3);
        chk("rd_fast_araddr", last_araddr, 64'h08);

        // slow read with error response
        r_lat = 5; rd_resp = 2'b10; rtab[r_idx] = 64'h2A;
        push_exp(64'h2A, 2'b10, 1'b0, 1);
        send_cmd(2'b01, 64'h10, 64'h0, 8'h0, 64'h0);
        wait_rsp("rd_slow", lat);
        chk("rd_slow_araddr", last_araddr, 64'h10);

        // poll that matches on the third read
        r_lat = 0; rd_resp = 2'b00;
        rtab[r_idx] = 64'd3; rtab[r_idx + 6'd1] = 64'd1; rtab[r_idx + 6'd2] = 64'd0;
        b_ar = ar_hs_n; b_gn = gap_n; b_gs = gap_sum;
        push_exp(64'd0, 2'b00, 1'b0, 3);
        send_cmd(2'b10, 64'h10, 64'h0, 8'h0, 64'hFF);
        wait_rsp("poll_match", lat);
        chk("poll_match_ar_hs", 64'(ar_hs_n - b_ar), 64'd3);
        chk("poll_match_gap_n", 64'(gap_n - b_gn), 64'd2);
        chk("poll_match_gap_sum", 64'(gap_sum - b_gs), 64'd4);
        chk("poll_match_last_gap", 64'(last_gap), 64'd2);

        // poll that never matches
        for (int k = 0; k < 4; k++) rtab[r_idx + 6'(k)] = 64'h11 + 64'(k);
        b_ar = ar_hs_n;
        push_exp(64'h14, 2'b00, 1'b1, 4);
        send_cmd(2'b10, 64'h40, 64'h55, 8'h0, 64'hFF);
        wait_rsp("poll_tmo", lat);
        chk("poll_tmo_ar_hs", 64'(ar_hs_n - b_ar), 64'd4);

        // back-pressured response, next command waiting, then reserved op
        rsp_ready = 1'b0; rtab[r_idx] = 64'h77;
        push_exp(64'h77, 2'b00, 1'b0, 1);
        push_exp(64'h0, 2'b10, 1'b0, 0);
        send_cmd(2'b01, 64'h30, 64'h0, 8'h0, 64'h0);
        cmd_op = 2'b11; cmd_addr = 64'h99; cmd_valid = 1'b1;
        lat = 0;
        do begin @(negedge aclk); lat++; end while (!rsp_valid && lat < 300);
        chk("bp_rsp_seen", 64'(rsp_valid), 64'd1);
        check_rsp("bp_rd");
        s_data = rsp_data; s_resp = rsp_resp; s_tmo = rsp_timeout; s_polls = rsp_polls;
        stable = 1'b1;
        b_ar = ar_hs_n; b_aw = aw_hs_n;
        repeat (6) begin
            @(negedge aclk);
            if (!rsp_valid || cmd_ready || rsp_data !== s_data || rsp_resp !== s_resp ||
                rsp_timeout !== s_tmo || rsp_polls !== s_polls) stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        rsp_ready = 1'b1;
        @(negedge aclk);
        chk("bp_cmd_ready_after", 64'(cmd_ready), 64'd1);
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
        @(negedge aclk);
        chk("rsv_rsp_valid", 64'(rsp_valid), 64'd1);
        check_rsp("rsv");
        chk("rsv_bus_valids", 64'({awvalid, wvalid, arvalid}), 64'd0);
        chk("rsv_no_bus", 64'((ar_hs_n - b_ar) + (aw_hs_n - b_aw)), 64'd0);
        @(posedge aclk);
        #1;

        // reset in the middle of a write
        aw_lat = 10; w_lat = 10;
        send_cmd(2'b00, 64'h50, 64'h3, 8'hFF, 64'h0);
        @(negedge aclk);
        chk("mid_rst_aw_before", 64'(awvalid), 64'd1);
        #2 areset = 1'b1;
        #1;
        chk("mid_rst_async", 64'({awvalid, wvalid, rsp_valid, cmd_ready}), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rst_idle_readies", 64'({bready, rready, awvalid}), 64'd0);

        // normal operation after reset
        aw_lat = 0; w_lat = 0;
        push_exp(64'd0, 2'b00, 1'b0, 0);
        send_cmd(2'b00, 64'h60, 64'h7, 8'h01, 64'h0);
        wait_rsp("wr_after_rst", lat);
        chk("wr_after_rst_latency", 64'(lat), 64'd3);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
